id_ex_reg: RTL



---
 rtl/id_ex_reg.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register: stall hold, flush bubble, valid bit.
// Optional perf counters (BubbleCntE/StallCntE) enabled by ID_EX_PERF_CNT_EN.
module id_ex_reg #(
  parameter int XLEN      = 32,
  parameter int ALUCTRL_W = 3,
  parameter int REG_AW    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 ValidD,
  input  logic                 RegWriteD,
  input  logic [1:0]           ResultSrcD,
  input  logic                 MemWriteD,
  input  logic                 JumpD,
  input  logic                 BranchD,
  input  logic                 ALUSrcAD,
  input  logic [1:0]           ALUSrcBD,
  input  logic                 PCJalSrcD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [2:0]           funct3D,
  input  logic [XLEN-1:0]      RD1D,
  input  logic [XLEN-1:0]      RD2D,
  input  logic [XLEN-1:0]      PCD,
  input  logic [XLEN-1:0]      PCPlus4D,
  input  logic [XLEN-1:0]      ImmExtD,
  input  logic [REG_AW-1:0]    Rs1D,
  input  logic [REG_AW-1:0]    Rs2D,
  input  logic [REG_AW-1:0]    RdD,
  output logic                 ValidE,
  output logic                 RegWriteE,
  output logic [1:0]           ResultSrcE,
  output logic                 MemWriteE,
  output logic                 JumpE,
  output logic                 BranchE,
  output logic                 ALUSrcAE,
  output logic [1:0]           ALUSrcBE,
  output logic                 PCJalSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic [2:0]           funct3E,
  output logic [XLEN-1:0]      RD1E,
  output logic [XLEN-1:0]      RD2E,
  output logic [XLEN-1:0]      PCE,
  output logic [XLEN-1:0]      PCPlus4E,
  output logic [XLEN-1:0]      ImmExtE,
  output logic [REG_AW-1:0]    Rs1E,
  output logic [REG_AW-1:0]    Rs2E,
  output logic [REG_AW-1:0]    RdE
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]          BubbleCntE,
  output logic [31:0]          StallCntE
`endif
);

  typedef struct packed {
    logic                 valid;
    logic                 reg_write;
    logic [1:0]           result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic                 pc_jal_src;
    logic [ALUCTRL_W-1:0] alu_control;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      rd1;
    logic [XLEN-1:0]      rd2;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_plus4;
    logic [XLEN-1:0]      imm_ext;
    logic [REG_AW-1:0]    rs1;
    logic [REG_AW-1:0]    rs2;
    logic [REG_AW-1:0]    rd;
  } id_ex_t;

  id_ex_t ex_d, ex_q;

  always_comb begin
    ex_d = ex_q;
    if (FlushE) begin
      ex_d = '0;
    end else if (!StallE) begin
      ex_d.valid       = ValidD;
      // gate with ValidD so an X from an illegal opcode never becomes
      // a side-effecting control bit on a bubble
      ex_d.reg_write   = ValidD ? RegWriteD : 1'b0;
      ex_d.mem_write   = ValidD ? MemWriteD : 1'b0;
      ex_d.jump        = ValidD ? JumpD     : 1'b0;
      ex_d.branch      = ValidD ? BranchD   : 1'b0;
      ex_d.result_src  = ResultSrcD;
      ex_d.alu_src_a   = ALUSrcAD;
      ex_d.alu_src_b   = ALUSrcBD;
      ex_d.pc_jal_src  = PCJalSrcD;
      ex_d.alu_control = ALUControlD;
      ex_d.funct3      = funct3D;
      ex_d.rd1         = RD1D;
      ex_d.rd2         = RD2D;
      ex_d.pc          = PCD;
      ex_d.pc_plus4    = PCPlus4D;
      ex_d.imm_ext     = ImmExtD;
      ex_d.rs1         = Rs1D;
      ex_d.rs2         = Rs2D;
      ex_d.rd          = RdD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ValidE      = ex_q.valid;
  assign RegWriteE   = ex_q.reg_write;
  assign ResultSrcE  = ex_q.result_src;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUSrcAE    = ex_q.alu_src_a;
  assign ALUSrcBE    = ex_q.alu_src_b;
  assign PCJalSrcE   = ex_q.pc_jal_src;
  assign ALUControlE = ex_q.alu_control;
  assign funct3E     = ex_q.funct3;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign ImmExtE     = ex_q.imm_ext;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] bub_cnt_d, bub_cnt_q;
  logic [31:0] stl_cnt_d, stl_cnt_q;
  logic        bub_ev, stl_ev;

  // a bubble enters E on a flush or on a load of an invalid slot
  assign bub_ev    = FlushE | (!StallE & !ValidD);
  assign stl_ev    = StallE & !FlushE;
  assign bub_cnt_d = bub_cnt_q + {31'd0, bub_ev};
  assign stl_cnt_d = stl_cnt_q + {31'd0, stl_ev};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bub_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      bub_cnt_q <= bub_cnt_d;
      stl_cnt_q <= stl_cnt_d;
    end
  end

  assign BubbleCntE = bub_cnt_q;
  assign StallCntE  = stl_cnt_q;
`else
  // counters absent in this build
`endif

endmodule
